// File: rtl/xor_stream_accum.sv
// -----------------------------------------------------------------------------
// xor_stream_accum
//
// Frame checksum / parity checker. Accumulates the bitwise XOR of a stream of
// WIDTH-bit words, frame by frame (frames end on in_last), and presents one
// registered result per frame through a valid/ready output. Frames longer than
// MAX_LEN beats are cut at MAX_LEN, flagged as overflowed, and their tail is
// swallowed without producing a second result.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear, abandons current frame and result
//   in_valid     input beat valid
//   in_ready     block can take an input beat (depends on state only)
//   in_data      input word
//   in_last      final beat of frame (sampled on accepted beats only)
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_xor      XOR of all accumulated beats
//   out_parity   XOR-reduction of out_xor (1 = odd number of ones)
//   out_count    beats accumulated (1..MAX_LEN)
//   out_overflow frame exceeded MAX_LEN; result covers first MAX_LEN beats
// -----------------------------------------------------------------------------
module xor_stream_accum #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    DONE = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             beat;
  logic             handshake;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;
  logic             closing;

  assign beat      = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign acc_next  = acc_q ^ in_data;
  // cnt_q never exceeds MAX_LEN-1 while accumulating, so the increment
  // always fits in CNT_W bits.
  assign cnt_inc   = cnt_q + 1'b1;
  assign at_max    = (cnt_inc == MAX_CNT);
  // A beat closes the frame either because the producer says so or because
  // the accumulator has reached its beat budget.
  assign closing   = in_last | at_max;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs. After an overflowed result is
  // taken, the machine goes to DROP to eat the rest of the oversized frame
  // so that its tail is not mistaken for the start of a new frame. clr wins
  // over every transition.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (beat && closing) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = out_overflow ? DROP : ACC;
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (beat && in_last) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
    if (clr) begin
      state_d = ACC;
    end
  end

  // Accumulator, beat counter and result registers. The result registers
  // are loaded only on the closing beat and otherwise hold, so the last
  // result stays visible after out_valid drops. The accumulator is cleared
  // when the result is handed off rather than on the closing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_xor      <= '0;
      out_parity   <= 1'b0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (clr) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_xor      <= '0;
      out_parity   <= 1'b0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat) begin
            acc_q <= acc_next;
            cnt_q <= cnt_inc;
            if (closing) begin
              out_xor      <= acc_next;
              out_parity   <= ^acc_next;
              out_count    <= cnt_inc;
              out_overflow <= ~in_last & at_max;
            end
          end
        end
        DONE: begin
          if (handshake) begin
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_stream_accum.sv
// -----------------------------------------------------------------------------
// tb_xor_stream_accum
//
// Directed bench for xor_stream_accum with WIDTH=8, MAX_LEN=4. Inputs are
// driven 1 ns after a rising edge and outputs are sampled there too, so each
// applyStimulus call represents exactly one clock cycle.
// -----------------------------------------------------------------------------
module tb_xor_stream_accum;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;

  int checks;
  int errors;

  xor_stream_accum #(
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_xor     (out_xor),
    .out_parity  (out_parity),
    .out_count   (out_count),
    .out_overflow(out_overflow)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then wait for the edge and settle 1 ns.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic l, input logic ordy,
                               input logic c);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  // Check the full result set while a result is being presented.
  task automatic checkResult(input string tag, input logic [7:0] x,
                             input logic p, input logic [CNT_W-1:0] n,
                             input logic ovf);
    checkOutput({tag, "_valid"},  32'(out_valid),    32'd1);
    checkOutput({tag, "_ready"},  32'(in_ready),     32'd0);
    checkOutput({tag, "_xor"},    32'(out_xor),      32'(x));
    checkOutput({tag, "_parity"}, 32'(out_parity),   32'(p));
    checkOutput({tag, "_count"},  32'(out_count),    32'(n));
    checkOutput({tag, "_ovf"},    32'(out_overflow), 32'(ovf));
  endtask

  // Take the pending result and confirm the block is idle again.
  task automatic takeResult(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_hs_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_valid",  32'(out_valid),    32'd0);
    checkOutput("rst_ready",  32'(in_ready),     32'd1);
    checkOutput("rst_xor",    32'(out_xor),      32'd0);
    checkOutput("rst_parity", 32'(out_parity),   32'd0);
    checkOutput("rst_count",  32'(out_count),    32'd0);
    checkOutput("rst_ovf",    32'(out_overflow), 32'd0);

    // Single beat frame: A5 has four ones -> parity 0
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
    checkResult("single", 8'hA5, 1'b0, 3'd1, 1'b0);
    takeResult("single");
    checkOutput("single_hold_xor", 32'(out_xor), 32'h0000_00A5);

    // Three-beat frame: 0F^F0^3C = C3, then a one-beat frame without carry-over
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkResult("three", 8'hC3, 1'b0, 3'd3, 1'b0);
    takeResult("three");
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    checkResult("fresh", 8'h01, 1'b1, 3'd1, 1'b0);
    takeResult("fresh");

    // Backpressure: result must hold while in_valid keeps pushing
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      checkResult("bp", 8'h33, 1'b0, 3'd2, 1'b0);
    end
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_hs_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_hs_ready", 32'(in_ready),  32'd1);
    // A consumed 0x77 would show up in this next frame's result
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
    checkResult("bp_next", 8'h40, 1'b1, 3'd1, 1'b0);
    takeResult("bp_next");

    // Overflow: 01^02^03^04 = 04 after four beats, tail 05, 06 dropped
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_pre_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    checkResult("ovf", 8'h04, 1'b1, 3'd4, 1'b1);
    takeResult("ovf");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    checkOutput("drop1_valid", 32'(out_valid), 32'd0);
    checkOutput("drop1_ready", 32'(in_ready),  32'd1);
    applyStimulus(1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
    checkOutput("drop2_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_idle_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
    checkResult("after_drop", 8'h80, 1'b1, 3'd1, 1'b0);
    takeResult("after_drop");

    // Exact MAX_LEN frame with last on the final beat: no overflow, no DROP
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b1, 1'b0, 1'b0);
    checkResult("exact", 8'h0F, 1'b0, 3'd4, 1'b0);
    takeResult("exact");
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    checkResult("exact_next", 8'h99, 1'b0, 3'd1, 1'b0);
    takeResult("exact_next");

    // clr mid-frame; the beat presented with clr is discarded
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_xor",   32'(out_xor),   32'd0);
    checkOutput("clr_count", 32'(out_count), 32'd0);
    checkOutput("clr_ready", 32'(in_ready),  32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_idle_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);
    checkResult("clr_next", 8'h0C, 1'b0, 3'd1, 1'b0);
    takeResult("clr_next");

    // Asynchronous reset pulse mid-frame (3 ns, between edges)
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("arst_valid",  32'(out_valid),    32'd0);
    checkOutput("arst_xor",    32'(out_xor),      32'd0);
    checkOutput("arst_parity", 32'(out_parity),   32'd0);
    checkOutput("arst_count",  32'(out_count),    32'd0);
    checkOutput("arst_ovf",    32'(out_overflow), 32'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_idle_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_idle_ready", 32'(in_ready),  32'd1);
    applyStimulus(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);
    checkResult("arst_next", 8'h0C, 1'b0, 3'd1, 1'b0);
    takeResult("arst_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
